// File: rtl/neuron_pkg.sv
// Shared types and constants for the top_neurons serial load transmitter.
package neuron_pkg;

  localparam int FP_DATA_WIDTH   = 16;
  localparam int TEN_DATA_WIDTH  = 2;
  localparam int NUM_NEURON      = 4;
  localparam int NEURON_ID_WIDTH = 2;
  localparam int Q_ROW_WIDTH     = NUM_NEURON * TEN_DATA_WIDTH;

  localparam logic [FP_DATA_WIDTH-1:0] HDR_WORD = 16'h0001;

  typedef enum logic [2:0] {IDLE, HDR, VMEM, MU, NID, QROW, GAP, DONE} state_t;

  typedef struct packed {
    logic [FP_DATA_WIDTH-1:0]   vmem;
    logic [FP_DATA_WIDTH-1:0]   mu;
    logic [NEURON_ID_WIDTH-1:0] nid;
    logic [Q_ROW_WIDTH-1:0]     q;
  } cfg_rec_t;

  // Zero-extended Q coupling entry idx of a row, as it appears on ins.
  function automatic logic [FP_DATA_WIDTH-1:0] q_word(input logic [Q_ROW_WIDTH-1:0] q,
                                                      input logic [NEURON_ID_WIDTH-1:0] idx);
    q_word = '0;
    q_word[TEN_DATA_WIDTH-1:0] = q[int'(idx)*TEN_DATA_WIDTH +: TEN_DATA_WIDTH];
  endfunction

  // Zero-extended neuron index, as it appears on ins.
  function automatic logic [FP_DATA_WIDTH-1:0] nid_word(input logic [NEURON_ID_WIDTH-1:0] nid);
    nid_word = '0;
    nid_word[NEURON_ID_WIDTH-1:0] = nid;
  endfunction

endpackage

// File: rtl/neuron_cfg_streamer_if.sv
// Valid/ready record channel from the host into the config streamer.
interface neuron_cfg_streamer_if;
  import neuron_pkg::*;

  logic                       cfg_valid;
  logic                       cfg_ready;
  logic [FP_DATA_WIDTH-1:0]   cfg_vmem;
  logic [FP_DATA_WIDTH-1:0]   cfg_mu;
  logic [NEURON_ID_WIDTH-1:0] cfg_nid;
  logic [Q_ROW_WIDTH-1:0]     cfg_q;

  modport master (output cfg_valid, cfg_vmem, cfg_mu, cfg_nid, cfg_q, input cfg_ready);
  modport slave  (input cfg_valid, cfg_vmem, cfg_mu, cfg_nid, cfg_q, output cfg_ready);

endinterface

// File: rtl/neuron_cfg_streamer_buf.sv
// One-entry record register: accepts a record when empty, emptied by the
// streamer when that record's VMEM slot begins.
module cfg_rec_buf
  import neuron_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  neuron_cfg_streamer_if.slave  cfg,
  input  logic                  free,
  output logic                  full,
  output cfg_rec_t              rec
);

  logic load;

  assign cfg.cfg_ready = !full;
  assign load          = cfg.cfg_valid && cfg.cfg_ready;

  // Occupancy flag; a load wins over a free in the same cycle.
  always_ff @(posedge clk) begin
    if (reset)     full <= 1'b0;
    else if (load) full <= 1'b1;
    else if (free) full <= 1'b0;
  end

  // Record payload, captured on accept only.
  always_ff @(posedge clk) begin
    if (load) begin
      rec.vmem <= cfg.cfg_vmem;
      rec.mu   <= cfg.cfg_mu;
      rec.nid  <= cfg.cfg_nid;
      rec.q    <= cfg.cfg_q;
    end
  end

endmodule

// File: rtl/neuron_cfg_streamer.sv
// Serializes buffered neuron config records onto the 16-bit ins load bus
// in fixed cycle slots: header, then Vmem/mu/nid/Q row/gap per neuron.
module neuron_cfg_streamer
  import neuron_pkg::*;
#(
  parameter int HOLD_CYC = 2,
  parameter int GAP_CYC  = 2
)(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  neuron_cfg_streamer_if.slave     cfg,
  output logic [FP_DATA_WIDTH-1:0] ins,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYC - 1);
  localparam logic [3:0] GAP_LAST  = 4'(GAP_CYC - 1);
  localparam logic [3:0] Q_LAST    = 4'(NUM_NEURON - 1);
  localparam logic [NEURON_ID_WIDTH-1:0] LAST_NEURON = NEURON_ID_WIDTH'(NUM_NEURON - 1);

  state_t                     state;
  logic [3:0]                 slot;
  logic [NEURON_ID_WIDTH-1:0] ncnt;
  logic [NEURON_ID_WIDTH-1:0] exp_nid;
  logic [NEURON_ID_WIDTH-1:0] q_next;
  logic                       vmem_try;
  logic                       vmem_ok;
  logic                       buf_full;
  cfg_rec_t                   buf_rec;
  cfg_rec_t                   cur;

  cfg_rec_buf u_buf (
    .clk   (clk),
    .reset (reset),
    .cfg   (cfg),
    .free  (vmem_ok),
    .full  (buf_full),
    .rec   (buf_rec)
  );

  assign q_next = NEURON_ID_WIDTH'(slot + 4'd1);

  // Decide whether this cycle ends in a VMEM entry and whether the buffered record qualifies.
  always_comb begin
    vmem_try = 1'b0;
    exp_nid  = ncnt;
    if (state == HDR) begin
      vmem_try = 1'b1;
      exp_nid  = '0;
    end else if (state == GAP && slot == GAP_LAST && ncnt != LAST_NEURON) begin
      vmem_try = 1'b1;
      exp_nid  = ncnt + 1'b1;
    end
    vmem_ok = vmem_try && buf_full && (buf_rec.nid == exp_nid);
  end

  // Working copy of the neuron being streamed, taken as the buffer is freed.
  always_ff @(posedge clk) begin
    if (vmem_ok) cur <= buf_rec;
  end

  // Frame sequencer with registered ins/busy/done/err.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ins   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
      slot  <= '0;
      ncnt  <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= HDR;
            ins   <= HDR_WORD;
            busy  <= 1'b1;
            slot  <= '0;
            ncnt  <= '0;
          end
        end
        HDR, GAP: begin
          if (state == GAP && slot != GAP_LAST) begin
            slot <= slot + 4'd1;
          end else if (state == GAP && ncnt == LAST_NEURON) begin
            state <= DONE;
            ins   <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (vmem_ok) begin
            state <= VMEM;
            ins   <= buf_rec.vmem;
            slot  <= '0;
            ncnt  <= exp_nid;
          end else begin
            state <= IDLE;
            ins   <= '0;
            busy  <= 1'b0;
            err   <= 1'b1;
            slot  <= '0;
          end
        end
        VMEM: begin
          if (slot == HOLD_LAST) begin
            state <= MU;
            ins   <= cur.mu;
            slot  <= '0;
          end else begin
            slot <= slot + 4'd1;
          end
        end
        MU: begin
          if (slot == HOLD_LAST) begin
            state <= NID;
            ins   <= nid_word(cur.nid);
            slot  <= '0;
          end else begin
            slot <= slot + 4'd1;
          end
        end
        NID: begin
          if (slot == HOLD_LAST) begin
            state <= QROW;
            ins   <= q_word(cur.q, '0);
            slot  <= '0;
          end else begin
            slot <= slot + 4'd1;
          end
        end
        QROW: begin
          if (slot == Q_LAST) begin
            state <= GAP;
            slot  <= '0;
          end else begin
            ins  <= q_word(cur.q, q_next);
            slot <= slot + 4'd1;
          end
        end
        DONE: begin
          state <= IDLE;
          ins   <= '0;
        end
        default: begin
          state <= IDLE;
          ins   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_cfg_streamer.sv
// Bench for neuron_cfg_streamer: frame-level model of the ins/busy/done/err
// trace, checked every cycle, plus hand-computed anchor values.
module tb_neuron_cfg_streamer;
  import neuron_pkg::*;

  localparam int H = 2;
  localparam int G = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] ins;
  logic        busy, done, err;

  neuron_cfg_streamer_if cfg_if ();

  neuron_cfg_streamer #(.HOLD_CYC(H), .GAP_CYC(G)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .cfg   (cfg_if.slave),
    .ins   (ins),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] ins;
    logic        busy;
    logic        done;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  cfg_rec_t    recs[4];
  logic [15:0] lit_trace[15];
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          chk_en = 0;
  bit          lit_en = 0;
  int          idx = 0;
  int          done_idx = -1;
  int          err_idx = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  function automatic logic [7:0] pack_q(input int e0, input int e1, input int e2, input int e3);
    return {2'(e3), 2'(e2), 2'(e1), 2'(e0)};
  endfunction

  task automatic push(input logic [15:0] w, input logic b, input logic d, input logic e);
    exp_t x;
    x.ins = w; x.busy = b; x.done = d; x.err = e;
    exp_q.push_back(x);
  endtask

  // Expected trace from the HDR cycle on, given how many records the host supplies.
  task automatic build_model(input int avail);
    exp_q.delete();
    push(16'h0001, 1, 0, 0);
    for (int n = 0; n < 4; n++) begin
      if (n >= avail || int'(recs[n].nid) != n) begin
        push(16'h0000, 0, 0, 1);
        push(16'h0000, 0, 0, 0);
        return;
      end
      for (int k = 0; k < H; k++) push(recs[n].vmem, 1, 0, 0);
      for (int k = 0; k < H; k++) push(recs[n].mu, 1, 0, 0);
      for (int k = 0; k < H; k++) push({14'b0, recs[n].nid}, 1, 0, 0);
      for (int j = 0; j < 4; j++) push({14'b0, recs[n].q[2*j +: 2]}, 1, 0, 0);
      for (int k = 0; k < G; k++) push({14'b0, recs[n].q[6 +: 2]}, 1, 0, 0);
    end
    push(16'h0000, 0, 1, 0);
    push(16'h0000, 0, 0, 0);
  endtask

  // Per-cycle comparison against the model, sampled on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (chk_en && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check($sformatf("ins[%0d]", idx), ins, e.ins);
      check($sformatf("busy[%0d]", idx), busy, e.busy);
      check($sformatf("done[%0d]", idx), done, e.done);
      check($sformatf("err[%0d]", idx), err, e.err);
      if (lit_en && idx < 15) check($sformatf("lit_ins[%0d]", idx), ins, lit_trace[idx]);
      if (done === 1'b1 && done_idx < 0) done_idx = idx;
      if (err === 1'b1 && err_idx < 0) err_idx = idx;
      idx++;
    end
  end

  task automatic do_reset();
    cfg_if.cfg_valid = 1'b0;
    start = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ins", ins, 16'h0000);
    check("rst_busy", busy, 1'b0);
    check("rst_ready", cfg_if.cfg_ready, 1'b1);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    reset = 1'b0;
  endtask

  task automatic feed(input int n);
    for (int k = 0; k < n; k++) begin
      int t;
      cfg_if.cfg_valid = 1'b1;
      cfg_if.cfg_vmem  = recs[k].vmem;
      cfg_if.cfg_mu    = recs[k].mu;
      cfg_if.cfg_nid   = recs[k].nid;
      cfg_if.cfg_q     = recs[k].q;
      t = 0;
      while (1) begin
        @(negedge clk);
        if (cfg_if.cfg_ready) break;
        t++;
        if (t > 400) begin
          check("feed_timeout", 32'd0, 32'd1);
          break;
        end
      end
      @(posedge clk);
      #1;
    end
    cfg_if.cfg_valid = 1'b0;
  endtask

  task automatic start_frame(input bit lit);
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    idx = 0;
    done_idx = -1;
    err_idx = -1;
    lit_en = lit;
    chk_en = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && exp_q.size() > 0; i++) @(posedge clk);
    check("drain", exp_q.size(), 0);
    chk_en = 1'b0;
    lit_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    lit_trace = '{16'h0001, 16'h0004, 16'h0004, 16'h4300, 16'h4300, 16'h0000, 16'h0000,
                  16'h0000, 16'h0001, 16'h0002, 16'h0000, 16'h0000, 16'h0000, 16'h0005,
                  16'h0005};
    recs[0] = '{16'h0004, 16'h4300, 2'd0, pack_q(0, 1, 2, 0)};
    recs[1] = '{16'h0005, 16'h4540, 2'd1, pack_q(2, 0, 1, 2)};
    recs[2] = '{16'hFFFA, 16'hC266, 2'd2, pack_q(1, 2, 0, 1)};
    recs[3] = '{16'h0001, 16'hABAE, 2'd3, pack_q(0, 1, 2, 0)};
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_vmem  = '0;
    cfg_if.cfg_mu    = '0;
    cfg_if.cfg_nid   = '0;
    cfg_if.cfg_q     = '0;

    // reset values
    do_reset();

    // full frame, records fed back-to-back
    build_model(4);
    fork
      feed(4);
      begin start_frame(1); drain(); end
    join
    check("s2_done_idx", done_idx, 49);
    check("s2_err_idx", err_idx, -1);

    // underrun after neuron 0
    do_reset();
    build_model(1);
    fork
      feed(1);
      begin start_frame(0); drain(); end
    join
    check("s3_err_idx", err_idx, 13);
    check("s3_busy_after", busy, 1'b0);

    // wrong neuron id in the first record
    do_reset();
    recs[0].nid = 2'd2;
    build_model(1);
    fork
      feed(1);
      begin start_frame(0); drain(); end
    join
    check("s4_err_idx", err_idx, 1);
    check("s4_buf_kept", cfg_if.cfg_ready, 1'b0);
    recs[0].nid = 2'd0;

    // reset during neuron 1 QROW
    do_reset();
    build_model(4);
    while (exp_q.size() > 21) void'(exp_q.pop_back());
    fork
      feed(4);
      begin
        start_frame(0);
        repeat (20) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        check("s5_ins", ins, 16'h0000);
        check("s5_busy", busy, 1'b0);
        check("s5_ready", cfg_if.cfg_ready, 1'b1);
        check("s5_done", done, 1'b0);
        check("s5_err", err, 1'b0);
        reset = 1'b0;
        check("s5_consumed", exp_q.size(), 0);
        chk_en = 1'b0;
      end
    join

    // start pulses mid-frame and during DONE are ignored
    do_reset();
    build_model(4);
    fork
      feed(4);
      begin
        start_frame(1);
        repeat (9) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (39) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        drain();
      end
    join
    check("s6_done_idx", done_idx, 49);
    check("s6_idle_after", busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
